// File: rtl/adder_arb_pkg.sv
// Shared defaults and types for the adder arbiter slice.
// Optional signed-overflow output is enabled with ADDER_ARB_OVF_EN.
package adder_arb_pkg;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 32;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} arb_state_t;
   typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr_i+1 upward with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               found_o
);
   logic [ID_W-1:0] ci;

   // Walk candidates from lowest to highest priority so the last hit wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found_o = 1'b0;
      ci      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         ci = ID_W'((int'(ptr_i) + k) % NUM_REQ);
         if (req_i[ci]) begin
            grant_o     = '0;
            grant_o[ci] = 1'b1;
            idx_o       = ci;
            found_o     = 1'b1;
         end
      end
      if (!en_i) begin
         grant_o = '0;
      end
   end
endmodule

// File: rtl/full_adder.sv
// Plain WIDTH-bit adder with carry-in and carry-out; the single shared instance.
module full_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);
   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/adder_arbiter.sv
// Shares one full_adder among NUM_REQ requesters with round-robin grant and a
// registered, ID-tagged response. Define ADDER_ARB_OVF_EN to add rsp_ovf.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_cin,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_sum,
`ifdef ADDER_ARB_OVF_EN
   output logic                     rsp_ovf,
`endif
   output logic                     rsp_cout
);
   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             can_accept, accept, found;
   logic [ID_W-1:0]  grant_idx;
   logic [WIDTH-1:0] a_arr [NUM_REQ];
   logic [WIDTH-1:0] b_arr [NUM_REQ];
   logic [WIDTH-1:0] a_sel, b_sel, add_sum;
   logic             cin_sel, add_cout;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Ready is held low during reset so no requester believes it was served.
   assign can_accept = !rst && ((state_q == IDLE) || (state_q == HOLD && rsp_ready));

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .en_i    (can_accept),
      .grant_o (req_ready),
      .idx_o   (grant_idx),
      .found_o (found)
   );

   assign accept  = can_accept && found;
   assign a_sel   = a_arr[grant_idx];
   assign b_sel   = b_arr[grant_idx];
   assign cin_sel = req_cin[grant_idx];

   full_adder #(.WIDTH(WIDTH)) u_add (
      .a     (a_sel),
      .b     (b_sel),
      .cin   (cin_sel),
      .sum   (add_sum),
      .c_out (add_cout)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      if (accept) begin
         state_d  = HOLD;
         rr_ptr_d = grant_idx;
         id_d     = grant_idx;
         sum_d    = add_sum;
         cout_d   = add_cout;
      end else if (state_q == HOLD && rsp_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= ID_W'(NUM_REQ-1);
         id_q     <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

`ifdef ADDER_ARB_OVF_EN
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (add_sum[WIDTH-1] != a_sel[WIDTH-1]);
      end
   end
   assign rsp_ovf = ovf_q;
`endif

   assign rsp_valid = (state_q == HOLD);
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter with hand-computed expectations.
module tb_adder_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_cin;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IW-1:0]  rsp_id;
   logic [W-1:0]   rsp_sum;
   logic           rsp_cout;
`ifdef ADDER_ARB_OVF_EN
   logic           rsp_ovf;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
`ifdef ADDER_ARB_OVF_EN
      .rsp_ovf   (rsp_ovf),
`endif
      .rsp_cout  (rsp_cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_cin[i]      = c;
      req_valid[i]    = 1'b1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_rsp(input string tag, input logic [IW-1:0] id, input logic [W-1:0] sum, input logic cout);
      check({tag, ".valid"}, rsp_valid, 1);
      check({tag, ".id"}, rsp_id, id);
      check({tag, ".sum"}, rsp_sum, sum);
      check({tag, ".cout"}, rsp_cout, cout);
   endtask

   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      rsp_ready = 1'b1;
      rst       = 1'b0;

      // Reset state
      do_reset();
      check("rst.valid", rsp_valid, 0);
      check("rst.id", rsp_id, 0);
      check("rst.sum", rsp_sum, 0);
      check("rst.cout", rsp_cout, 0);
      check("rst.ready", req_ready, 0);
`ifdef ADDER_ARB_OVF_EN
      check("rst.ovf", rsp_ovf, 0);
`endif

      // Single op: 1 + 2 + 1 = 4
      set_req(0, 32'd1, 32'd2, 1'b1);
      #1 check("single.ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      check_rsp("single", 0, 32'd4, 0);
      tick();
      check("single.drain", rsp_valid, 0);

      // Round-robin with all requesters continuously valid
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 32'(10*i), 32'd20, 1'b0);
      for (int k = 0; k < 5; k++) begin
         #1 check($sformatf("rr%0d.ready", k), req_ready, 4'b0001 << (k % N));
         tick();
         check_rsp($sformatf("rr%0d", k), IW'(k % N), 32'(20 + 10*(k % N)), 0);
      end
      req_valid = '0;
      tick();

      // Backpressure: req1 held while rsp_ready is low
      do_reset();
      rsp_ready = 1'b0;
      set_req(1, 32'd55, 32'd66, 1'b1);
      #1 check("bp.ready1", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      set_req(2, 32'd5, 32'd6, 1'b0);
      for (int k = 0; k < 3; k++) begin
         check_rsp($sformatf("bp.hold%0d", k), 1, 32'd122, 0);
         check($sformatf("bp.noready%0d", k), req_ready, 0);
         tick();
      end
      rsp_ready = 1'b1;
      #1 check("bp.ready2", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      check_rsp("bp.next", 2, 32'd11, 0);
      tick();
      check("bp.drain", rsp_valid, 0);

      // Wrap-around and back-to-back accept
      set_req(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      tick();
      check_rsp("wrap", 0, 32'd0, 1);
`ifdef ADDER_ARB_OVF_EN
      check("wrap.ovf", rsp_ovf, 0);
`endif
      set_req(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
      #1 check("b2b.ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      check_rsp("sovf", 0, 32'h8000_0000, 0);
`ifdef ADDER_ARB_OVF_EN
      check("sovf.ovf", rsp_ovf, 1);
`endif
      tick();

      // Reset mid-operation with req3 pending
      rsp_ready = 1'b0;
      set_req(1, 32'd7, 32'd8, 1'b0);
      tick();
      req_valid = '0;
      check_rsp("rmid.held", 1, 32'd15, 0);
      set_req(3, 32'd100, 32'd200, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rsp_ready = 1'b1;
      check("rmid.valid", rsp_valid, 0);
      #1 check("rmid.ready", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      check_rsp("rmid.rsp", 3, 32'd300, 0);
      tick();

      // Idle cycles do not rotate priority
      do_reset();
      set_req(2, 32'd1, 32'd1, 1'b0);
      tick();
      req_valid = '0;
      check_rsp("idle.r2", 2, 32'd2, 0);
      for (int k = 0; k < 6; k++) tick();
      set_req(0, 32'd3, 32'd4, 1'b0);
      set_req(3, 32'd9, 32'd9, 1'b1);
      #1 check("idle.ready3", req_ready, 4'b1000);
      tick();
      req_valid[3] = 1'b0;
      check_rsp("idle.r3", 3, 32'd19, 0);
      #1 check("idle.ready0", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      check_rsp("idle.r0", 0, 32'd7, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
